// File: rtl/sig_splice_pkg.sv
// Shared types and helpers for the sig_splice lane splicer.
// Map entries are sized for the default lane geometry.
package sig_splice_pkg;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      APPLY
   } state_t;

   localparam int MAP_SEL_W  = 3;
   localparam int MAP_LANE_W = 4;

   typedef struct packed {
      logic [MAP_SEL_W-1:0]  sel;
      logic [MAP_LANE_W-1:0] cnst;
   } map_ent_t;

   function automatic int lanes(
      input int ch,
      input int ch_w,
      input int lane_w
   );
      return (ch * ch_w) / lane_w;
   endfunction

endpackage

// File: rtl/sig_splice_lane_mux.sv
// One output lane: an input lane picked by sel, or the constant
// when sel is out of the input lane range.
module sig_splice_lane_mux
   import sig_splice_pkg::*;
#(
   parameter int L_IN   = 4,
   parameter int LANE_W = 4,
   parameter int SEL_W  = 3
) (
   input  logic [L_IN*LANE_W-1:0] in_data,
   input  logic [SEL_W-1:0]       sel,
   input  logic [LANE_W-1:0]      cnst,
   output logic [LANE_W-1:0]      lane
);

   always_comb begin
      lane = cnst;
      for (int i = 0; i < L_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            lane = in_data[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/sig_splice_pipe.sv
// Registered, handshaked lane splicer with a shadowed runtime map.
// Optional per-channel parity output: define SIG_SPLICE_PARITY_EN.
module sig_splice_pipe
   import sig_splice_pkg::*;
#(
   parameter  int NUM_CH = 2,
   parameter  int OUT_CH = 2,
   parameter  int CH_W   = 8,
   parameter  int LANE_W = 4,
   localparam int L_IN   = lanes(NUM_CH, CH_W, LANE_W),
   localparam int L_OUT  = lanes(OUT_CH, CH_W, LANE_W),
   localparam int SEL_W  = $clog2(L_IN + 1),
   localparam int LN_W   = $clog2(L_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_CH*CH_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_CH*CH_W-1:0] out_data,
   input  logic                   cfg_we,
   input  logic [LN_W-1:0]        cfg_lane,
   input  logic [SEL_W-1:0]       cfg_sel,
   input  logic [LANE_W-1:0]      cfg_const,
   input  logic                   cfg_commit,
   output logic                   cfg_busy,
`ifdef SIG_SPLICE_PARITY_EN
   output logic [OUT_CH-1:0]      out_par,
`endif
   output logic [15:0]            beat_cnt
);

   state_t                 state;
   map_ent_t               shadow [L_OUT];
   map_ent_t               active [L_OUT];
   logic [OUT_CH*CH_W-1:0] spliced;
   logic                   accept;

   function automatic map_ent_t ident(input int k);
      map_ent_t e;
      e.sel  = MAP_SEL_W'(k % L_IN);
      e.cnst = '0;
      return e;
   endfunction

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign cfg_busy = (state != RUN);

   for (genvar k = 0; k < L_OUT; k++) begin : g_lane
      sig_splice_lane_mux #(
         .L_IN  (L_IN),
         .LANE_W(LANE_W),
         .SEL_W (SEL_W)
      ) u_mux (
         .in_data(in_data),
         .sel    (SEL_W'(active[k].sel)),
         .cnst   (LANE_W'(active[k].cnst)),
         .lane   (spliced[k*LANE_W +: LANE_W])
      );
   end

   // Active map only moves in APPLY, when no beat is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         for (int k = 0; k < L_OUT; k++) begin
            shadow[k] <= ident(k);
            active[k] <= ident(k);
         end
      end else begin
         for (int k = 0; k < L_OUT; k++) begin
            if (cfg_we && (cfg_lane == LN_W'(k))) begin
               shadow[k].sel  <= MAP_SEL_W'(cfg_sel);
               shadow[k].cnst <= MAP_LANE_W'(cfg_const);
            end
         end
         unique case (state)
            RUN: begin
               if (cfg_commit) state <= DRAIN;
            end
            DRAIN: begin
               if (!out_valid || out_ready) state <= APPLY;
            end
            APPLY: begin
               active <= shadow;
               state  <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         beat_cnt  <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= spliced;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 16'd1;
         end
      end
   end

`ifdef SIG_SPLICE_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par <= '0;
      end else if (accept) begin
         for (int c = 0; c < OUT_CH; c++) begin
            out_par[c] <= ^spliced[c*CH_W +: CH_W];
         end
      end
   end
`endif

endmodule

// File: tb/tb_sig_splice_pipe.sv
// Directed self-checking bench for sig_splice_pipe.
// Parity checks run when SIG_SPLICE_PARITY_EN is defined.
module tb_sig_splice_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        cfg_we;
   logic [1:0]  cfg_lane;
   logic [2:0]  cfg_sel;
   logic [3:0]  cfg_const;
   logic        cfg_commit;
   logic        cfg_busy;
   logic [15:0] beat_cnt;
`ifdef SIG_SPLICE_PARITY_EN
   logic [1:0]  out_par;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sig_splice_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_lane  (cfg_lane),
      .cfg_sel   (cfg_sel),
      .cfg_const (cfg_const),
      .cfg_commit(cfg_commit),
      .cfg_busy  (cfg_busy),
`ifdef SIG_SPLICE_PARITY_EN
      .out_par   (out_par),
`endif
      .beat_cnt  (beat_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      cfg_we     = 1'b0;
      cfg_lane   = '0;
      cfg_sel    = '0;
      cfg_const  = '0;
      cfg_commit = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] l, input logic [2:0] s,
                            input logic [3:0] c);
      cfg_we    = 1'b1;
      cfg_lane  = l;
      cfg_sel   = s;
      cfg_const = c;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic commit_wait(input string nm);
      int n;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      n = 0;
      while (cfg_busy && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (cfg_busy !== 1'b0) begin
         $display("FAIL %s commit timeout busy=%b want 0", nm, cfg_busy);
         errors++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (out_valid !== 1'b0) begin
         $display("FAIL rst_out_valid got %b want 0", out_valid); errors++;
      end
      if (out_data !== 16'h0000) begin
         $display("FAIL rst_out_data got %h want 0000", out_data); errors++;
      end
      if (cfg_busy !== 1'b0) begin
         $display("FAIL rst_busy got %b want 0", cfg_busy); errors++;
      end
      if (beat_cnt !== 16'h0000) begin
         $display("FAIL rst_beat_cnt got %h want 0000", beat_cnt); errors++;
      end
      if (in_ready !== 1'b1) begin
         $display("FAIL rst_in_ready got %b want 1", in_ready); errors++;
      end
   endtask

   task automatic test_passthru();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hA5C3;
      tick();
      in_valid = 1'b0;
      checks += 2;
      if (out_valid !== 1'b1) begin
         $display("FAIL pass_valid got %b want 1", out_valid); errors++;
      end
      if (out_data !== 16'hA5C3) begin
         $display("FAIL pass_data got %h want a5c3", out_data); errors++;
      end
      tick();
      checks += 2;
      if (beat_cnt !== 16'd1) begin
         $display("FAIL pass_cnt got %0d want 1", beat_cnt); errors++;
      end
      if (out_valid !== 1'b0) begin
         $display("FAIL pass_drop got %b want 0", out_valid); errors++;
      end
   endtask

   task automatic test_map();
      do_reset();
      out_ready = 1'b1;
      cfg_write(2'd3, 3'd2, 4'h0);
      cfg_write(2'd2, 3'd0, 4'h0);
      cfg_write(2'd1, 3'd4, 4'hA);
      cfg_write(2'd0, 3'd0, 4'h0);
      commit_wait("map");
      in_valid = 1'b1;
      in_data  = 16'h4321;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 16'h31A1) begin
         $display("FAIL map_data got %h want 31a1", out_data); errors++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h1111;
      tick();
      in_data = 16'h2222;
      checks += 2;
      if (out_data !== 16'h1111) begin
         $display("FAIL stall_first got %h want 1111", out_data); errors++;
      end
      if (in_ready !== 1'b0) begin
         $display("FAIL stall_ready got %b want 0", in_ready); errors++;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 2;
         if (out_data !== 16'h1111) begin
            $display("FAIL stall_hold[%0d] got %h want 1111", i, out_data);
            errors++;
         end
         if (in_ready !== 1'b0) begin
            $display("FAIL stall_rdy[%0d] got %b want 0", i, in_ready);
            errors++;
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL stall_release got %b want 1", in_ready); errors++;
      end
      tick();
      in_valid = 1'b0;
      checks += 2;
      if (out_data !== 16'h2222) begin
         $display("FAIL stall_next got %h want 2222", out_data); errors++;
      end
      if (beat_cnt !== 16'd1) begin
         $display("FAIL stall_cnt1 got %0d want 1", beat_cnt); errors++;
      end
      tick();
      checks += 2;
      if (beat_cnt !== 16'd2) begin
         $display("FAIL stall_cnt2 got %0d want 2", beat_cnt); errors++;
      end
      if (out_valid !== 1'b0) begin
         $display("FAIL stall_empty got %b want 0", out_valid); errors++;
      end
   endtask

   task automatic test_commit();
      do_reset();
      cfg_write(2'd0, 3'd4, 4'hF);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h1234;
      tick();
      in_data    = 16'h5678;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      checks += 3;
      if (cfg_busy !== 1'b1) begin
         $display("FAIL cm_busy got %b want 1", cfg_busy); errors++;
      end
      if (in_ready !== 1'b0) begin
         $display("FAIL cm_rdy got %b want 0", in_ready); errors++;
      end
      if (out_data !== 16'h1234) begin
         $display("FAIL cm_old got %h want 1234", out_data); errors++;
      end
      cfg_write(2'd1, 3'd4, 4'h9);
      checks++;
      if (cfg_busy !== 1'b1) begin
         $display("FAIL cm_drain got %b want 1", cfg_busy); errors++;
      end
      out_ready = 1'b1;
      tick();
      checks += 4;
      if (cfg_busy !== 1'b1) begin
         $display("FAIL cm_apply_busy got %b want 1", cfg_busy); errors++;
      end
      if (out_valid !== 1'b0) begin
         $display("FAIL cm_apply_valid got %b want 0", out_valid); errors++;
      end
      if (in_ready !== 1'b0) begin
         $display("FAIL cm_apply_rdy got %b want 0", in_ready); errors++;
      end
      if (beat_cnt !== 16'd1) begin
         $display("FAIL cm_cnt got %0d want 1", beat_cnt); errors++;
      end
      tick();
      checks += 2;
      if (cfg_busy !== 1'b0) begin
         $display("FAIL cm_done got %b want 0", cfg_busy); errors++;
      end
      if (in_ready !== 1'b1) begin
         $display("FAIL cm_run_rdy got %b want 1", in_ready); errors++;
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 16'h569F) begin
         $display("FAIL cm_new got %h want 569f", out_data); errors++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0000;
      repeat (65536) tick();
      checks++;
      if (beat_cnt !== 16'hFFFF) begin
         $display("FAIL wrap_max got %h want ffff", beat_cnt); errors++;
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (beat_cnt !== 16'h0000) begin
         $display("FAIL wrap_zero got %h want 0000", beat_cnt); errors++;
      end
   endtask

   task automatic test_reset_mid_commit();
      do_reset();
      cfg_write(2'd0, 3'd4, 4'h5);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h1234;
      tick();
      in_valid   = 1'b0;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      checks++;
      if (cfg_busy !== 1'b1) begin
         $display("FAIL mid_busy got %b want 1", cfg_busy); errors++;
      end
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin
         $display("FAIL mid_valid got %b want 0", out_valid); errors++;
      end
      if (cfg_busy !== 1'b0) begin
         $display("FAIL mid_rst_busy got %b want 0", cfg_busy); errors++;
      end
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h1234;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 16'h1234) begin
         $display("FAIL mid_ident got %h want 1234", out_data); errors++;
      end
      commit_wait("mid_recommit");
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 16'hBEEF) begin
         $display("FAIL mid_shadow got %h want beef", out_data); errors++;
      end
   endtask

   task automatic test_parity();
      do_reset();
`ifdef SIG_SPLICE_PARITY_EN
      checks++;
      if (out_par !== 2'b00) begin
         $display("FAIL par_rst got %b want 00", out_par); errors++;
      end
`endif
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0701;
      tick();
      in_data = 16'h0301;
      checks++;
      if (out_data !== 16'h0701) begin
         $display("FAIL par_data got %h want 0701", out_data); errors++;
      end
`ifdef SIG_SPLICE_PARITY_EN
      checks++;
      if (out_par !== 2'b11) begin
         $display("FAIL par_0701 got %b want 11", out_par); errors++;
      end
`endif
      tick();
      in_valid = 1'b0;
`ifdef SIG_SPLICE_PARITY_EN
      checks++;
      if (out_par !== 2'b01) begin
         $display("FAIL par_0301 got %b want 01", out_par); errors++;
      end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_passthru();
      test_map();
      test_stall();
      test_commit();
      test_wrap();
      test_reset_mid_commit();
      test_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
